// File: rtl/drive_cmd_pkg.sv
// Shared command, source and scheduler-state encodings for the drive command path.
// Used by the scheduler, the JSON translator and the vision classifier.
package drive_cmd_pkg;

   typedef enum logic [2:0] {
      STOP       = 3'd0,
      FAST_LEFT  = 3'd1,
      LEFT       = 3'd2,
      STRAIGHT   = 3'd3,
      RIGHT      = 3'd4,
      HARD_RIGHT = 3'd5
   } cmd_e;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      VISION  = 2'd1,
      MANUAL  = 2'd2,
      ESTOP   = 2'd3
   } src_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      GAP
   } sched_state_e;

   localparam int unsigned RETRY_CYC = 4;

   // The gap counter starts part-way so that WAIT_DONE, IDLE, ISSUE and the output
   // register together make exactly MIN_GAP_CYC quiet cycles after tx_busy falls.
   localparam logic [31:0] GAP_PRELOAD = 32'd4;

   function automatic cmd_e sanitize_cmd(input logic [2:0] code);
      return (code > 3'd5) ? STOP : cmd_e'(code);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable 32-bit saturating up-counter with clear, enable and a terminal flag.
module cycle_timer
   import drive_cmd_pkg::*;
#(
   parameter int unsigned TERMINAL = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        en,
   output logic        done
);

   logic [31:0] count_q, count_d;

   // Clear beats load beats count; counting stops at TERMINAL so it never wraps.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en && (count_q < TERMINAL)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q >= TERMINAL);

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates vision / manual / estop steering and paces single-cycle issues to the translator.
// Optional keepalive resend is enabled by defining DRIVE_SCHED_KEEPALIVE_EN.
module drive_cmd_scheduler
   import drive_cmd_pkg::*;
#(
   parameter int unsigned MIN_GAP_CYC   = 2_500_000,
   parameter int unsigned KEEPALIVE_CYC = 25_000_000,
   parameter int unsigned WATCHDOG_CYC  = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] vis_cmd,
   input  logic       vis_valid,
   input  logic [2:0] man_cmd,
   input  logic       man_valid,
   input  logic       man_override,
   input  logic       estop,
   input  logic       tx_busy,
   output logic [2:0] cmd_out,
   output logic       cmd_valid,
   output logic [1:0] active_src,
   output logic       wd_tripped
);

   sched_state_e state_q, state_d;
   cmd_e         vis_q, vis_d, man_q, man_d, cmd_out_q, cmd_out_d, eff_cmd;
   src_e         active_src_q, active_src_d, eff_src;
   logic         estop_q, override_q;
   logic         wd_tripped_q, wd_tripped_d;
   logic         force_send_q, force_send_d;
   logic         cmd_valid_q, cmd_valid_d;
   logic [1:0]   ws_cnt_q, ws_cnt_d;
   logic         wd_done, gap_done, ka_due, changed, estop_rise, retry_timeout;

   cycle_timer #(.TERMINAL(WATCHDOG_CYC)) u_watchdog (
      .clk(clk), .reset(reset), .clr(vis_valid), .load(1'b0),
      .load_val(32'd0), .en(1'b1), .done(wd_done)
   );

   cycle_timer #(.TERMINAL(MIN_GAP_CYC)) u_gap (
      .clk(clk), .reset(reset), .clr(1'b0),
      .load((state_q == WAIT_DONE) && !tx_busy),
      .load_val(GAP_PRELOAD), .en(state_q == GAP), .done(gap_done)
   );

`ifdef DRIVE_SCHED_KEEPALIVE_EN
   cycle_timer #(.TERMINAL(KEEPALIVE_CYC)) u_keepalive (
      .clk(clk), .reset(reset), .clr(state_q == ISSUE), .load(1'b0),
      .load_val(32'd0), .en(1'b1), .done(ka_due)
   );
`else
   assign ka_due = 1'b0;
`endif

   always_comb begin
      vis_d        = vis_q;
      man_d        = man_q;
      wd_tripped_d = wd_tripped_q;
      if (vis_valid) vis_d = sanitize_cmd(vis_cmd);
      if (man_valid) man_d = sanitize_cmd(man_cmd);
      if (vis_valid) begin
         wd_tripped_d = 1'b0;
      end else if (wd_done) begin
         wd_tripped_d = 1'b1;
      end
   end

   // A source change alone counts as a change, so a STOP from a new owner is re-announced.
   always_comb begin
      eff_cmd = vis_q;
      eff_src = VISION;
      if (estop_q) begin
         eff_cmd = STOP;
         eff_src = ESTOP;
      end else if (override_q) begin
         eff_cmd = man_q;
         eff_src = MANUAL;
      end else if (wd_tripped_q) begin
         eff_cmd = STOP;
         eff_src = NONE;
      end
   end

   assign changed       = (eff_cmd != cmd_out_q) || (eff_src != active_src_q);
   assign estop_rise    = estop && !estop_q;
   assign retry_timeout = (state_q == WAIT_START) && !tx_busy && (ws_cnt_q == 2'(RETRY_CYC - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (!tx_busy && (changed || ka_due || force_send_q)) state_d = ISSUE;
         ISSUE:      state_d = WAIT_START;
         WAIT_START: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (retry_timeout) begin
               state_d = IDLE;
            end
         end
         WAIT_DONE:  if (!tx_busy) state_d = GAP;
         GAP:        if (estop_rise || gap_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_out_d    = cmd_out_q;
      active_src_d = active_src_q;
      cmd_valid_d  = 1'b0;
      force_send_d = force_send_q;
      ws_cnt_d     = 2'd0;
      case (state_q)
         ISSUE: begin
            cmd_out_d    = eff_cmd;
            active_src_d = eff_src;
            cmd_valid_d  = 1'b1;
            force_send_d = 1'b0;
         end
         WAIT_START: begin
            ws_cnt_d = ws_cnt_q + 2'd1;
            if (retry_timeout) force_send_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vis_q        <= STOP;
         man_q        <= STOP;
         estop_q      <= 1'b0;
         override_q   <= 1'b0;
         wd_tripped_q <= 1'b1;
         force_send_q <= 1'b1;
         cmd_out_q    <= STOP;
         cmd_valid_q  <= 1'b0;
         active_src_q <= NONE;
         ws_cnt_q     <= 2'd0;
      end else begin
         vis_q        <= vis_d;
         man_q        <= man_d;
         estop_q      <= estop;
         override_q   <= man_override;
         wd_tripped_q <= wd_tripped_d;
         force_send_q <= force_send_d;
         cmd_out_q    <= cmd_out_d;
         cmd_valid_q  <= cmd_valid_d;
         active_src_q <= active_src_d;
         ws_cnt_q     <= ws_cnt_d;
      end
   end

   assign cmd_out    = cmd_out_q;
   assign cmd_valid  = cmd_valid_q;
   assign active_src = active_src_q;
   assign wd_tripped = wd_tripped_q;

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler with a 10-cycle translator model.
// Keepalive expectations follow DRIVE_SCHED_KEEPALIVE_EN when it is defined for the build.
module tb_drive_cmd_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] vis_cmd = 3'd0;
   logic       vis_valid = 1'b0;
   logic [2:0] man_cmd = 3'd0;
   logic       man_valid = 1'b0;
   logic       man_override = 1'b0;
   logic       estop = 1'b0;
   logic       tx_busy;
   logic [2:0] cmd_out;
   logic       cmd_valid;
   logic [1:0] active_src;
   logic       wd_tripped;

   typedef struct packed {
      logic       estop;
      logic       ovr;
      logic [2:0] man;
      logic [2:0] vis;
      logic [2:0] exp_cmd;
      logic [1:0] exp_src;
   } vec_t;

   vec_t       vecs [7];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   bit         vis_auto = 1'b0;
   logic [2:0] vis_code = 3'd0;
   bit         drop_issue = 1'b0;
   int         busy_left = 0;

   drive_cmd_scheduler #(
      .MIN_GAP_CYC(8), .KEEPALIVE_CYC(64), .WATCHDOG_CYC(32)
   ) dut (
      .clk(clk), .reset(reset), .vis_cmd(vis_cmd), .vis_valid(vis_valid),
      .man_cmd(man_cmd), .man_valid(man_valid), .man_override(man_override),
      .estop(estop), .tx_busy(tx_busy), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
      .active_src(active_src), .wd_tripped(wd_tripped)
   );

   initial forever #5 clk = ~clk;

   // Translator: busy for 10 cycles starting the cycle after it sees cmd_valid.
   always @(posedge clk) begin
      if (cmd_valid && !drop_issue) begin
         busy_left <= 10;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end
   end
   assign tx_busy = (busy_left != 0);

   function automatic int pair(input int c, input int s);
      return c * 4 + s;
   endfunction

   function automatic int got_pair();
      return int'(cmd_out) * 4 + int'(active_src);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      vis_valid = vis_auto && (cyc % 5 == 0);
      vis_cmd   = vis_code;
      man_valid = 1'b0;
   endtask

   task automatic pulseVis(input logic [2:0] code);
      vis_code  = code;
      vis_cmd   = code;
      vis_valid = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      estop        = v.estop;
      man_override = v.ovr;
      man_cmd      = v.man;
      man_valid    = 1'b1;
      pulseVis(v.vis);
   endtask

   task automatic waitIssue(input int bound, output bit seen, output int waited);
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < bound) begin
         step();
         waited++;
         if (cmd_valid) seen = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got 1 expected 0");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit seen;
      int waited, issues, n, low_at, issue_at, issue_pair;

      vecs[0] = '{estop: 1'b0, ovr: 1'b1, man: 3'd5, vis: 3'd1, exp_cmd: 3'd5, exp_src: 2'd2};
      vecs[1] = '{estop: 1'b0, ovr: 1'b0, man: 3'd5, vis: 3'd1, exp_cmd: 3'd1, exp_src: 2'd1};
      vecs[2] = '{estop: 1'b1, ovr: 1'b0, man: 3'd5, vis: 3'd1, exp_cmd: 3'd0, exp_src: 2'd3};
      vecs[3] = '{estop: 1'b0, ovr: 1'b1, man: 3'd6, vis: 3'd2, exp_cmd: 3'd0, exp_src: 2'd2};
      vecs[4] = '{estop: 1'b1, ovr: 1'b1, man: 3'd2, vis: 3'd2, exp_cmd: 3'd0, exp_src: 2'd3};
      vecs[5] = '{estop: 1'b0, ovr: 1'b0, man: 3'd2, vis: 3'd7, exp_cmd: 3'd0, exp_src: 2'd1};
      vecs[6] = '{estop: 1'b0, ovr: 1'b0, man: 3'd2, vis: 3'd5, exp_cmd: 3'd5, exp_src: 2'd1};

      repeat (3) step();
      checkOutput("reset_state", int'({cmd_out, cmd_valid, active_src, wd_tripped}), int'(7'b000_0_00_1));
      reset = 1'b0;

      waitIssue(10, seen, waited);
      checkOutput("first_issue_latency", waited, 2);
      checkOutput("first_issue_cmd_src", got_pair(), pair(0, 0));
      step();
      checkOutput("cmd_valid_single_cycle", int'(cmd_valid), 0);

      vis_auto = 1'b1;
      pulseVis(3'd3);
      waitIssue(40, seen, waited);
      checkOutput("vis3_issue", got_pair(), pair(3, 1));
      checkOutput("wd_clear_on_vis", int'(wd_tripped), 0);

      issues = 0;
      repeat (50) begin
         step();
         if (cmd_valid) issues++;
      end
      checkOutput("no_repeat_issue", issues, 0);
`ifdef DRIVE_SCHED_KEEPALIVE_EN
      waitIssue(30, seen, waited);
      checkOutput("keepalive_seen", int'(seen), 1);
      checkOutput("keepalive_interval_ok", int'((50 + waited >= 64) && (50 + waited <= 68)), 1);
      checkOutput("keepalive_cmd", got_pair(), pair(3, 1));
`else
      issues = 0;
      repeat (40) begin
         step();
         if (cmd_valid) issues++;
      end
      checkOutput("no_keepalive_issue", issues, 0);
`endif

      pulseVis(3'd2);
      waitIssue(40, seen, waited);
      checkOutput("vis2_issue", got_pair(), pair(2, 1));

      // New code arrives mid-transmission; it must follow exactly 8 quiet cycles.
      step();
      step();
      checkOutput("busy_during_wait_done", int'(tx_busy), 1);
      pulseVis(3'd4);
      n = 0;
      while (tx_busy && n < 20) begin
         step();
         n++;
      end
      waitIssue(20, seen, waited);
      checkOutput("gap_after_busy_falls", waited, 8);
      checkOutput("vis4_issue", got_pair(), pair(4, 1));

      n = 0;
      while (!tx_busy && n < 5) begin
         step();
         n++;
      end
      while (tx_busy && n < 25) begin
         step();
         n++;
      end
      step();
      step();
      estop = 1'b1;
      waitIssue(20, seen, waited);
      checkOutput("estop_aborts_gap", int'(seen && waited <= 3), 1);
      checkOutput("estop_issue", got_pair(), pair(0, 3));

      estop        = 1'b0;
      man_override = 1'b1;
      man_cmd      = 3'd7;
      man_valid    = 1'b1;
      waitIssue(40, seen, waited);
      checkOutput("man7_sanitized", got_pair(), pair(0, 2));

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         waitIssue(40, seen, waited);
         checkOutput($sformatf("prio_vec%0d", i), got_pair(),
                     pair(int'(vecs[i].exp_cmd), int'(vecs[i].exp_src)));
      end

      vis_auto = 1'b0;
      pulseVis(3'd5);
      n = 0;
      while (!wd_tripped && n < 60) begin
         step();
         n++;
      end
      checkOutput("wd_trip_time_ok", int'(n >= 32 && n <= 35), 1);
      waitIssue(40, seen, waited);
      checkOutput("wd_stop_issue", got_pair(), pair(0, 0));

      step();
      vis_auto = 1'b1;
      pulseVis(3'd2);
      step();
      checkOutput("wd_cleared", int'(wd_tripped), 0);
      waitIssue(40, seen, waited);
      checkOutput("wd_recover_issue", got_pair(), pair(2, 1));

      drop_issue = 1'b1;
      pulseVis(3'd3);
      waitIssue(40, seen, waited);
      checkOutput("dropped_issue", got_pair(), pair(3, 1));
      waitIssue(12, seen, waited);
      drop_issue = 1'b0;
      checkOutput("retry_interval_ok", int'(seen && waited >= 5 && waited <= 7), 1);
      checkOutput("retry_cmd", got_pair(), pair(3, 1));

      vis_auto = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      low_at     = -1;
      issue_at   = -1;
      issue_pair = -1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (!tx_busy && low_at < 0) low_at = k;
         if (cmd_valid && issue_at < 0) begin
            issue_at   = k;
            issue_pair = got_pair();
         end
      end
      checkOutput("reset_mid_tx_wait", issue_at - low_at, 2);
      checkOutput("reset_mid_tx_stop", issue_pair, pair(0, 0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/drive_cmd_scheduler.md
# drive_cmd_scheduler

Sequences steering commands into the JSON command translator that feeds the robot UART. Arbitrates between the vision pipeline, a manual override source and an emergency stop. Issues a single-cycle `cmd_valid` only when the translator is idle. Applies change detection, a minimum inter-command gap, periodic keepalive resends and a vision watchdog that forces STOP on stale detections.

## Interface
- `MIN_GAP_CYC`, 2_500_000: idle cycles enforced after each transmission completes (50 ms at 50 MHz).
- `KEEPALIVE_CYC`, 25_000_000: cycles after the last issue before the current command is resent.
- `WATCHDOG_CYC`, 25_000_000: cycles without `vis_valid` before vision is declared stale.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high.
- `vis_cmd` in 3: vision steering code.
- `vis_valid` in 1: one-cycle strobe per processed frame.
- `man_cmd` in 3: manual steering code.
- `man_valid` in 1: strobe to latch `man_cmd`.
- `man_override` in 1: level; manual has priority over vision while high.
- `estop` in 1: level; forces STOP, highest priority.
- `tx_busy` in 1: translator busy, driven by translator `cmd_ready`.
- `cmd_out` out 3: command code to the translator.
- `cmd_valid` out 1: one-cycle issue pulse.
- `active_src` out 2: source of the last issued command: 0 = none/stop, 1 = vision, 2 = manual, 3 = estop.
- `wd_tripped` out 1: vision watchdog expired.

## Operation
- Latches:
  - `vis_cmd` is captured on `vis_valid`; `man_cmd` is captured on `man_valid`.
  - Any code above 5 is stored as 0 (STOP).
- Effective command, in priority order:
  - `estop` gives 0 with source 3.
  - Else `man_override` gives the latched manual command with source 2.
  - Else `wd_tripped` gives 0 with source 0.
  - Else the latched vision command with source 1.
- Watchdog counter:
  - Cleared by `vis_valid`.
  - Reaching `WATCHDOG_CYC` sets `wd_tripped`; the next `vis_valid` clears it.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - Moves to ISSUE if the effective command differs from `last_sent`, or the keepalive has expired, or `force_send` is set.
  - Nothing happens while `tx_busy` is high.
- ISSUE:
  - Drives `cmd_out` with the effective command and pulses `cmd_valid` for one cycle.
  - Updates `last_sent` and `active_src`, clears `force_send`, restarts the keepalive counter.
  - Goes to WAIT_START.
- WAIT_START:
  - Waits for `tx_busy` = 1, then goes to WAIT_DONE.
  - If `tx_busy` stays low for 4 cycles, sets `force_send` and returns to IDLE (lost-issue retry).
- WAIT_DONE: waits for `tx_busy` = 0, then goes to GAP. This state cannot be preempted.
- GAP:
  - Counts `MIN_GAP_CYC` cycles, then returns to IDLE.
  - A rising edge of `estop` in GAP aborts the gap and goes to IDLE immediately.
- `cmd_out` holds its value between issues.

## Timing
- Reset values:
  - `cmd_out` = 0, `cmd_valid` = 0, `active_src` = 0, `wd_tripped` = 1.
  - `last_sent` = 0, `force_send` = 1, state = IDLE, all counters = 0.
  - The first STOP is therefore issued 2 cycles after `reset` deasserts.
- Issue latency: `cmd_valid` is high 2 cycles after the edge that samples an input change, provided the FSM is in IDLE with `tx_busy` low.
- Reset mid-transmission: the scheduler returns to IDLE and reissues STOP once `tx_busy` = 0.
- `vis_valid` and `man_valid` in the same cycle as ISSUE: the new values are latched and compared against `last_sent` on the next IDLE.
- `estop` toggling high then low within one WAIT_DONE: only the effective command present at the next IDLE is sent.
- Counters are 32-bit unsigned and saturate at their terminal value; they never wrap.

## Configuration
- `DRIVE_SCHED_KEEPALIVE_EN`:
  - Defined: the keepalive counter and resend trigger are present.
  - Undefined: commands are issued only on change, reset or lost-issue retry. The keepalive counter is not synthesized and `KEEPALIVE_CYC` is ignored.

## Structure
- Package `drive_cmd_pkg` holds:
  - `cmd_e` (STOP = 0, FAST_LEFT = 1, LEFT = 2, STRAIGHT = 3, RIGHT = 4, HARD_RIGHT = 5).
  - `src_e` (NONE, VISION, MANUAL, ESTOP).
  - `sched_state_e`.
  - Shared with the translator and the vision classifier.
- Sub-module `cycle_timer`: a loadable saturating counter with clear, enable and terminal flag, instantiated for watchdog, keepalive and gap.

## Test plan
Benches use `MIN_GAP_CYC` = 8, `KEEPALIVE_CYC` = 64, `WATCHDOG_CYC` = 32, with a translator model that holds `tx_busy` for 10 cycles starting one cycle after `cmd_valid`.
- Release reset -> `cmd_valid` 2 cycles later with `cmd_out` = 0, `active_src` = 0.
- After the gap, `vis_valid` with `vis_cmd` = 3 -> one issue of 3, `active_src` = 1. Repeating 3 every 5 cycles -> no further issue until keepalive (macro on) at 64 cycles.
- `vis_cmd` = 4 during WAIT_DONE -> issue of 4 exactly 8 cycles after `tx_busy` falls.
- `estop` asserted during GAP -> STOP issued within 2 cycles, `active_src` = 3. `man_override` with `man_cmd` = 7 -> issue of 0, `active_src` = 2.
- No `vis_valid` for 32 cycles -> `wd_tripped` = 1 and STOP issued. Next `vis_valid` with code 2 -> `wd_tripped` = 0 and issue of 2.
- `tx_busy` held low after `cmd_valid` -> retry issue of the same command after 4 cycles.
